inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Upstream stage of the controller: owns the PC, fetches 16-bit instructions from a
//  handshaked instruction memory, holds them in an instruction register and presents
//  opcode/func/imm to the controller. Computes the next PC from the controller's
//  branch/jump decisions once the datapath retires the instruction.
// PARAMETERS
//  PC_W     12  PC / instruction-memory address width (words)
//  INST_W   16  instruction width; opcode=[15:12], imm=[11:0], func=[7:0]
//  TIMEOUT  15  max FETCH cycles without imem_ack (only with FETCH_TIMEOUT_EN)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active low
//  imem_req    out  1       fetch request, held until imem_ack
//  imem_addr   out  PC_W    fetch address (= pc while imem_req=1)
//  imem_ack    in   1       read data valid this cycle
//  imem_rdata  in   INST_W  instruction word
//  opcode      out  4       IR[15:12] to controller
//  func        out  8       IR[7:0] to controller
//  imm         out  12      IR[11:0] (jump target / branch offset)
//  pc          out  PC_W    address of instruction in IR
//  inst_valid  out  1       IR holds a valid instruction (EXEC state)
//  exec_done   in   1       datapath retires IR this cycle
//  branch_sel  in   1       controller: conditional branch
//  zero_flag   in   1       ALU zero flag
//  jump_sel    in   1       controller: unconditional jump
//  fetch_fault out  1       sticky fetch timeout (0 unless FETCH_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=0, IR=0, imem_req=0, inst_valid=0, fetch_fault=0,
//   state=FETCH; outputs change immediately, not at next edge.
//  FSM states: FETCH, EXEC, HALT.
//   FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> IR<=imem_rdata, ->EXEC.
//   EXEC : inst_valid=1, imem_req=0. exec_done=1 -> pc<=next_pc, ->FETCH.
//   HALT : imem_req=0, inst_valid=0; exit only by reset.
//  First imem_req in first cycle after rst_n deasserts. Zero-wait memory (ack in
//   first FETCH cycle) => 2 cycles/instruction minimum; inst_valid 1 cycle after ack.
//  next_pc (PC_W-bit, modulo 2^PC_W, wraps 4095->0):
//   jump_sel=1                -> imm[PC_W-1:0]       (jump wins over branch)
//   branch_sel=1 & zero_flag=1 -> pc+1+sext(imm[7:0])
//   otherwise                 -> pc+1
//  imem_ack outside FETCH ignored; exec_done outside EXEC ignored.
//  opcode/func/imm/pc stable throughout EXEC; IR unchanged during FETCH.
//  Reset during FETCH drops imem_req same instant; pending ack is discarded.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: wait counter cleared on entering FETCH, +1 per FETCH
//   cycle without ack; if count==TIMEOUT with no ack -> fetch_fault<=1 (sticky),
//   ->HALT next cycle. Ack on the TIMEOUT-th cycle is accepted normally.
//  Not defined: no counter, fetch_fault tied 0, FETCH waits indefinitely, HALT unreachable.
// STRUCTURE
//  cpu_pkg: OPCODE_W=4, FUNC_W=8, IMM_W=12, fetch state enum (FETCH/EXEC/HALT),
//   reset PC constant RESET_PC=0.
//  Sub-module ifu_next_pc: combinational next_pc from pc, imm, branch_sel,
//   zero_flag, jump_sel; instantiated once.
// TESTING
//  1 Reset, zero-wait mem, mem[0]=16'h1234 -> imem_req=1 addr=0 cycle 1; opcode=1,
//    func=8'h34, imm=12'h234, inst_valid=1 next cycle.
//  2 exec_done, no branch/jump at pc=5 -> next fetch addr=6; pc=4095 -> addr=0.
//  3 pc=10, branch_sel=1, zero_flag=1, imm[7:0]=8'hFE -> addr 9; zero_flag=0 -> 11.
//  4 jump_sel=1 & branch_sel=1 & zero_flag=1, imm=12'h080 -> addr 12'h080.
//  5 ack delayed 3 cycles -> imem_req, addr held 4 cycles, IR updated on ack only;
//    rst_n pulse mid-wait -> imem_req=0 immediately, refetch from addr 0.
//  6 FETCH_TIMEOUT_EN, no ack -> fetch_fault=1 after 15 cycles, imem_req=0 and stays
//    until reset; without macro, fetch_fault=0 and imem_req held.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, reset PC and fetch FSM encoding for the instruction fetch unit.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int FUNC_W   = 8;
  localparam int IMM_W    = 12;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC select: jump target, PC-relative branch (sign-extended imm[7:0]) or PC+1.
// All arithmetic wraps modulo 2^PC_W.
module ifu_next_pc
  import cpu_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic             branch_sel_i,
  input  logic             zero_flag_i,
  input  logic             jump_sel_i,
  output logic [PC_W-1:0]  next_pc_o
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_off;

  assign seq_pc = pc_i + PC_W'(1);
  assign br_off = {{(PC_W - 8){imm_i[7]}}, imm_i[7:0]};

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc_o = seq_pc;
    if (jump_sel_i) begin
      next_pc_o = PC_W'(imm_i);
    end else if (branch_sel_i && zero_flag_i) begin
      next_pc_o = seq_pc + br_off;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a handshaked imem, holds the IR for the controller.
// Optional FETCH_TIMEOUT_EN: sticky fetch_fault and HALT after TIMEOUT fetch cycles without imem_ack.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int INST_W = 16
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [IMM_W-1:0]    imm,
  output logic [PC_W-1:0]     pc,
  output logic                inst_valid,
  input  logic                exec_done,
  input  logic                branch_sel,
  input  logic                zero_flag,
  input  logic                jump_sel,
  output logic                fetch_fault
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, next_pc;
  logic [INST_W-1:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;
`endif

  ifu_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc_i         (pc_q),
    .imm_i        (ir_q[IMM_W-1:0]),
    .branch_sel_i (branch_sel),
    .zero_flag_i  (zero_flag),
    .jump_sel_i   (jump_sel),
    .next_pc_o    (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_d     = wait_q;
    fault_d    = fault_q;
`endif
    unique case (state_q)
      FETCH: begin
        // Gating with rst_n drops the request the instant reset asserts.
        imem_req = rst_n;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          wait_d = wait_q + CNT_W'(1);
          if (wait_d == CNT_W'(TIMEOUT)) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
`endif
      end
      EXEC: begin
        inst_valid = 1'b1;
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_q[INST_W-1 -: OPCODE_W];
  assign func      = ir_q[FUNC_W-1:0];
  assign imm       = ir_q[IMM_W-1:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: random imem latency and controller decisions against a PC-sequence model.
module tb_inst_fetch_unit;

  localparam int NPC = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [3:0]  opcode;
  logic [7:0]  func;
  logic [11:0] imm;
  logic [11:0] pc;
  logic        inst_valid;
  logic        exec_done = 1'b0;
  logic        branch_sel = 1'b0;
  logic        zero_flag = 1'b0;
  logic        jump_sel = 1'b0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  inst_fetch_unit #(.PC_W(12), .INST_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode), .func(func),
    .imm(imm), .pc(pc), .inst_valid(inst_valid), .exec_done(exec_done),
    .branch_sel(branch_sel), .zero_flag(zero_flag), .jump_sel(jump_sel),
    .fetch_fault(fetch_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, in plain integer arithmetic.
  function automatic int ref_next_pc(input int cur, input int im, input logic [2:0] c);
    int off;
    if (c[2]) return im % NPC;
    if (c[1] && c[0]) begin
      off = im % 256;
      if (off >= 128) off -= 256;
      return (cur + 1 + off + NPC) % NPC;
    end
    return (cur + 1) % NPC;
  endfunction

  typedef struct {
    int          pc;
    logic [15:0] word;
    int          ack_cyc;
  } exp_t;

  logic [15:0] mem [NPC];
  int          fetch_q[$];
  exp_t        inst_q[$];
  int          cyc = 0;

  // Directed prologue: ack delays per fetch and {jump,branch,zero} per retired instruction.
  int          dir_delay [12] = '{0, 1, 0, 3, 2, 0, 14, 0, 1, 0, 0, 2};
  logic [2:0]  plan [11] = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000,
                             3'b100, 3'b011, 3'b100, 3'b010, 3'b111};

  bit ack_en    = 1'b1;
  bit long_next = 1'b0;
  int fetch_idx = 0;
  int inst_idx  = 0;
  int n_retired = 0;

  always @(posedge clk) cyc++;

  // Instruction memory responder.
  int wcnt = 0, req_cycles = 0, cur_delay = 0, a;
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack   = 1'b0;
      wcnt       = 0;
      req_cycles = 0;
      fetch_q.delete();
      fetch_q.push_back(0);
      inst_q.delete();
    end else if (imem_req) begin
      if (req_cycles == 0) begin
        if (long_next) begin
          cur_delay = 8;
          long_next = 1'b0;
        end else if (fetch_idx < 12) cur_delay = dir_delay[fetch_idx];
        else cur_delay = $urandom_range(0, 4);
        fetch_idx++;
      end
      req_cycles++;
      if (fetch_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fetch_unexpected: addr %0h with no fetch outstanding at %0t", imem_addr, $time);
      end else chk("imem_addr", 32'(imem_addr), fetch_q[0]);
      if (ack_en && wcnt == cur_delay && fetch_q.size() != 0) begin
        chk("req_hold_cycles", req_cycles, cur_delay + 1);
        a = fetch_q.pop_front();
        imem_ack   = 1'b1;
        imem_rdata = mem[a];
        inst_q.push_back('{pc: a, word: mem[a], ack_cyc: cyc});
        req_cycles = 0;
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      // Stray acks with junk data while not fetching must be ignored.
      imem_ack   = ($urandom_range(0, 3) == 0);
      imem_rdata = 16'($urandom);
      wcnt       = 0;
      req_cycles = 0;
    end
  end

  // Controller/datapath stand-in: retires instructions and predicts the next fetch address.
  int         model_pc = 0;
  bit         issued = 1'b0;
  logic [2:0] ctl;
  always @(negedge clk) begin
    if (!rst_n) begin
      exec_done = 1'b0; jump_sel = 1'b0; branch_sel = 1'b0; zero_flag = 1'b0;
      model_pc  = 0;
      issued    = 1'b0;
    end else if (inst_valid && !issued) begin
      if ($urandom_range(0, 2) != 0) begin
        if (inst_idx < 11) ctl = plan[inst_idx];
        else ctl = {($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        jump_sel   = ctl[2];
        branch_sel = ctl[1];
        zero_flag  = ctl[0];
        exec_done  = 1'b1;
        model_pc   = ref_next_pc(model_pc, int'(mem[model_pc][11:0]), ctl);
        fetch_q.push_back(model_pc);
        issued = 1'b1;
        inst_idx++;
      end else begin
        exec_done  = 1'b0;
        jump_sel   = 1'($urandom_range(0, 1));
        branch_sel = 1'($urandom_range(0, 1));
        zero_flag  = 1'($urandom_range(0, 1));
      end
    end else if (!inst_valid) begin
      issued     = 1'b0;
      exec_done  = ($urandom_range(0, 3) == 0);
      jump_sel   = 1'($urandom_range(0, 1));
      branch_sel = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
    end else begin
      exec_done = 1'b0;
    end
  end

  // Monitor: pops the expected instruction when inst_valid rises; checks IR stability otherwise.
  bit          prev_v = 1'b0;
  exp_t        cur;
  logic [15:0] last_word = 16'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v    = 1'b0;
      last_word = 16'h0;
    end else begin
      if (inst_valid && !prev_v) begin
        if (inst_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL inst_unexpected: inst_valid with pc %0h and nothing fetched at %0t", pc, $time);
        end else begin
          cur = inst_q.pop_front();
          chk("inst_latency", cyc, cur.ack_cyc + 1);
          last_word = cur.word;
          n_retired++;
        end
      end
      if (inst_valid) begin
        chk("exec_pc", 32'(pc), cur.pc);
        chk("exec_opcode", 32'(opcode), 32'(cur.word[15:12]));
        chk("exec_func", 32'(func), 32'(cur.word[7:0]));
        chk("exec_imm", 32'(imm), 32'(cur.word[11:0]));
      end else begin
        chk("ir_hold", 32'({opcode, imm}), 32'(last_word));
      end
      prev_v = inst_valid;
    end
  end

  initial begin
    for (int i = 0; i < NPC; i++) mem[i] = 16'($urandom);
    mem[0]      = 16'h1234;
    mem[12'h234] = 16'h0005;
    mem[6]      = 16'h0FFF;
    mem[1]      = 16'h000A;
    mem[10]     = 16'h00FE;
    mem[9]      = 16'h000A;
    mem[11]     = 16'h0080;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ir", 32'({opcode, imm}), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 0);

    for (int i = 0; i < 20000 && n_retired < 160; i++) @(negedge clk);
    chk("retire_progress", 32'(n_retired >= 160), 1);

    // Reset in the middle of a long memory wait.
    long_next = 1'b1;
    for (int i = 0; i < 2000 && !(imem_req && cur_delay == 8 && req_cycles >= 3); i++) @(posedge clk);
    chk("long_wait_reached", 32'(imem_req && cur_delay == 8 && req_cycles >= 3), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midwait_req_drop", 32'(imem_req), 0);
    chk("midwait_inst_valid", 32'(inst_valid), 0);
    chk("midwait_pc", 32'(pc), 0);
    chk("midwait_ir", 32'({opcode, imm}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("refetch_req", 32'(imem_req), 1);
    chk("refetch_addr", 32'(imem_addr), 0);
    begin
      int target;
      target = n_retired + 5;
      for (int i = 0; i < 2000 && n_retired < target; i++) @(negedge clk);
      chk("post_reset_progress", 32'(n_retired >= target), 1);
    end

    // Memory never answers.
    ack_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
      chk("timeout_req", 32'(imem_req), 32'(k <= 15));
      chk("timeout_fault", 32'(fetch_fault), 32'(k > 15));
`else
      chk("noack_req_held", 32'(imem_req), 1);
      chk("noack_no_fault", 32'(fetch_fault), 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
